// File: rtl/twiddle_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : twiddle_seq_ctrl_pkg
// Brief  : Shared FFT geometry and twiddle sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package twiddle_seq_ctrl_pkg;

  localparam int FFT_SIZE   = 32;
  localparam int FFT_STAGES = 4;
  localparam int FFT_AW     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/twiddle_seq_ctrl_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module : twiddle_addr_cnt
// Brief  : ROM address counter with enable, clear and terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
module twiddle_addr_cnt
  import twiddle_seq_ctrl_pkg::*;
#(
  parameter int AW   = FFT_AW,
  parameter int LAST = FFT_SIZE - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [AW-1:0] cnt,
  output logic          wrap
);

  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == AW'(LAST)) ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = (r_cnt == AW'(LAST));

endmodule
`default_nettype wire

// File: rtl/twiddle_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : twiddle_seq_ctrl
// Brief  : Sequences twiddle ROM reads across all FFT stages of one frame.
// Rev    : 1.0  initial release
// ============================================================================
module twiddle_seq_ctrl
  import twiddle_seq_ctrl_pkg::*;
#(
  parameter  int SIZE   = FFT_SIZE,
  parameter  int STAGES = FFT_STAGES,
  parameter  int AW     = FFT_AW,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ready,
  output logic [AW-1:0] rom_addr,
  output logic [SW-1:0] stage_sel,
  output logic          rd_en,
  output logic          coeff_valid,
  output logic [SW-1:0] coeff_stage,
  output logic          busy,
  output logic          done
);

  seq_state_e    r_state;
  seq_state_e    w_next;
  logic [SW-1:0] r_stage;
  logic          r_cv;
  logic [SW-1:0] r_cstage;
  logic          w_rd_en;
  logic          w_clr;
  logic          w_cnt_en;
  logic          w_stage_inc;
  logic          w_at_wrap;
  logic          w_last_stage;

  assign w_last_stage = (r_stage == SW'(STAGES - 1));

  twiddle_addr_cnt #(
    .AW   (AW),
    .LAST (SIZE - 1)
  ) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (w_cnt_en),
    .clr  (w_clr),
    .cnt  (rom_addr),
    .wrap (w_at_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_stage  <= '0;
      r_cv     <= 1'b0;
      r_cstage <= '0;
    end else begin
      r_state  <= w_next;
      r_cv     <= w_rd_en;
      r_cstage <= r_stage;
      if (w_clr) begin
        r_stage <= '0;
      end else if (w_stage_inc) begin
        r_stage <= r_stage + 1'b1;
      end
    end
  end

  // The final read of a frame leaves address and stage parked; only a new start or abort clears them.
  always_comb begin
    w_next      = r_state;
    w_rd_en     = 1'b0;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;
    w_stage_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_next = ST_RUN;
          w_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        w_rd_en = ready;
        if (abort) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end else if (ready) begin
          if (w_at_wrap && w_last_stage) begin
            w_next = ST_DRAIN;
          end else begin
            w_cnt_en    = 1'b1;
            w_stage_inc = w_at_wrap;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_next = ST_IDLE;
          w_clr  = 1'b1;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign stage_sel   = r_stage;
  assign rd_en       = w_rd_en;
  assign coeff_valid = r_cv;
  assign coeff_stage = r_cstage;
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_twiddle_seq_ctrl
// Brief  : Scoreboard bench for the twiddle sequencer against a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_twiddle_seq_ctrl;
  import twiddle_seq_ctrl_pkg::*;

  localparam int SIZE   = FFT_SIZE;
  localparam int STAGES = FFT_STAGES;
  localparam int AW     = FFT_AW;
  localparam int SW     = $clog2(STAGES);
  localparam int TOTAL  = SIZE * STAGES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] stage_sel;
  logic          rd_en;
  logic          coeff_valid;
  logic [SW-1:0] coeff_stage;
  logic          busy;
  logic          done;

  twiddle_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .ready       (ready),
    .rom_addr    (rom_addr),
    .stage_sel   (stage_sel),
    .rd_en       (rd_en),
    .coeff_valid (coeff_valid),
    .coeff_stage (coeff_stage),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic busy;
    logic done;
    logic rd;
    logic cv;
    logic chk;
    int   addr;
    int   stage;
  } rec_t;

  rec_t cyc_q[$];
  int   coeff_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Frame-level reference: progress is just the count of reads issued so far.
  int   m_phase   = 0;   // 0 idle, 1 reading, 2 drain, 3 done
  int   m_reads   = 0;
  logic m_prev_rd = 1'b0;
  logic m_cleared = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_model(input logic st, input logic ab, input logic rdy);
    rec_t r;
    r.busy  = (m_phase == 1) || (m_phase == 2);
    r.done  = (m_phase == 3);
    r.rd    = (m_phase == 1) && rdy;
    r.cv    = m_prev_rd;
    r.chk   = (m_phase == 1) || (m_phase == 0 && m_cleared);
    r.addr  = (m_phase == 1) ? m_reads % SIZE : 0;
    r.stage = (m_phase == 1) ? m_reads / SIZE : 0;
    cyc_q.push_back(r);
    if (r.rd) coeff_q.push_back(m_reads / SIZE);
    m_prev_rd = r.rd;
    case (m_phase)
      0: if (st && !ab) begin m_phase = 1; m_reads = 0; m_cleared = 1'b0; end
      1: begin
        if (ab) begin
          m_phase = 0; m_reads = 0; m_cleared = 1'b1;
        end else if (rdy) begin
          m_reads++;
          if (m_reads == TOTAL) m_phase = 2;
        end
      end
      2: if (ab) begin m_phase = 0; m_reads = 0; m_cleared = 1'b1; end
         else m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle(input logic st, input logic ab, input logic rdy);
    @(posedge clk);
    #1;
    start = st;
    abort = ab;
    ready = rdy;
    step_model(st, ab, rdy);
  endtask

  task automatic push_idle_rec();
    rec_t r;
    r.busy = 1'b0; r.done = 1'b0; r.rd = 1'b0; r.cv = 1'b0;
    r.chk = 1'b1; r.addr = 0; r.stage = 0;
    cyc_q.push_back(r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'(($urandom_range(0, 1)));
    #1;
    rst = 1'b0;
    #1;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_stage_sel", int'(stage_sel), 0);
    check("rst_coeff_stage", int'(coeff_stage), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_coeff_valid", int'(coeff_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    coeff_q.delete();
    m_phase = 0; m_reads = 0; m_prev_rd = 1'b0; m_cleared = 1'b1;
    push_idle_rec();
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_idle_rec();
  endtask

  task automatic run_until(input int reads, input logic st);
    int guard = 0;
    while (m_reads < reads && guard < 2000) begin
      cycle(st, 1'b0, 1'b1);
      guard++;
    end
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        r = cyc_q.pop_front();
        check("busy", int'(busy), int'(r.busy));
        check("done", int'(done), int'(r.done));
        check("rd_en", int'(rd_en), int'(r.rd));
        check("coeff_valid", int'(coeff_valid), int'(r.cv));
        if (r.chk) begin
          check("rom_addr", int'(rom_addr), r.addr);
          check("stage_sel", int'(stage_sel), r.stage);
        end
      end
      if (coeff_valid) begin
        if (coeff_q.size() > 0) check("coeff_stage", int'(coeff_stage), coeff_q.pop_front());
        else check("coeff_unexpected", 1, 0);
      end
    end
  end

  initial begin : stim
    do_reset();
    // full frame, ready always high
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < TOTAL + 4; i++) cycle(1'b0, 1'b0, 1'b1);
    // ready alternating 1,0
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * TOTAL + 6; i++) cycle(1'b0, 1'b0, 1'(i % 2 == 0));
    // abort at stage 2 addr 10
    cycle(1'b1, 1'b0, 1'b1);
    run_until(2 * SIZE + 10, 1'b0);
    cycle(1'b0, 1'b1, 1'(($urandom_range(0, 1))));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    // start and abort together in idle
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    // start held high through a frame and into the next
    for (int i = 0; i < TOTAL + 10; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    // reset at stage 1 addr 31, then a fresh frame
    cycle(1'b1, 1'b0, 1'b1);
    run_until(2 * SIZE - 1, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < TOTAL * 2 + 10; i++) cycle(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    check("cyc_q_empty", cyc_q.size(), 0);
    check("coeff_q_empty", coeff_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/twiddle_seq_ctrl.md
TWIDDLE_SEQ_CTRL -- requirements
Module: twiddle_seq_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 32, coefficient entries per stage ROM.
REQ-002 SHALL have parameter STAGES, default 4, number of FFT stages sequenced per frame.
REQ-003 SHALL have parameter AW, default 5, ROM address width; SIZE = 2**AW.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle frame start request.
REQ-007 SHALL have port abort  input  1  synchronous frame cancel.
REQ-008 SHALL have port ready  input  1  butterfly datapath can accept a coefficient this cycle.
REQ-009 SHALL have port rom_addr  output  AW  address driven to every coeff_mem_<stage>_<lane> ROM.
REQ-010 SHALL have port stage_sel  output  clog2(STAGES)  selects which stage ROM bank feeds the datapath.
REQ-011 SHALL have port rd_en  output  1  ROM read strobe for this cycle.
REQ-012 SHALL have port coeff_valid  output  1  ROM data on coeff_out is valid this cycle.
REQ-013 SHALL have port coeff_stage  output  clog2(STAGES)  stage tag aligned with coeff_valid.
REQ-014 SHALL have port busy  output  1  high from accepted start until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL go to RUN with rom_addr=0, stage_sel=0, busy=1 next cycle.
REQ-018 RUN: rd_en SHALL equal ready (combinational); rom_addr/stage_sel advance only on rd_en=1.
REQ-019 RUN with ready=0 SHALL hold rom_addr and stage_sel unchanged (stall, no skipped or repeated read).
REQ-020 On rd_en with rom_addr=SIZE-1 and stage_sel<STAGES-1: rom_addr wraps to 0 and stage_sel increments in the same cycle.
REQ-021 On rd_en with rom_addr=SIZE-1 and stage_sel=STAGES-1: go to DRAIN; rom_addr/stage_sel hold.
REQ-022 DRAIN SHALL last exactly one cycle (covers 1-cycle ROM latency), then DONE.
REQ-023 DONE SHALL assert done=1 for one cycle, busy=0 in that cycle, then IDLE.
REQ-024 coeff_valid SHALL equal rd_en delayed one cycle; coeff_stage SHALL equal stage_sel delayed one cycle.
REQ-025 Exactly SIZE*STAGES rd_en pulses SHALL occur per uninterrupted frame (128 at defaults).
REQ-026 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-027 abort=1 in RUN or DRAIN SHALL return to IDLE next cycle, clear rom_addr/stage_sel, suppress done; in-flight coeff_valid still pulses once if rd_en was high.
REQ-028 abort and start both high in IDLE: abort wins, stays IDLE.
REQ-029 start in the DONE cycle SHALL be ignored; new frame needs start in IDLE.

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, rom_addr=0, stage_sel=0, coeff_stage=0, rd_en=0, coeff_valid=0, busy=0, done=0.
REQ-031 Reset mid-frame SHALL discard progress; first start after release begins at stage 0, address 0.
REQ-032 Reset deassertion SHALL be synchronised externally; no output toggles in the release cycle.

Structure
REQ-033 SHALL place SIZE, STAGES, AW and the FSM state encoding in the shared fft package used by the coeff_mem blocks.
REQ-034 SHALL contain one natural sub-module, twiddle_addr_cnt (AW-bit address counter with wrap flag, enable, clear).
REQ-035 SHALL contain no ROM storage; ROMs stay in the coeff_mem_<stage>_<lane> instances.

Verification
REQ-036 start pulse, ready=1 always -> rd_en high 128 cycles, rom_addr 0..31 four times, stage_sel 0,1,2,3, done one cycle after DRAIN.
REQ-037 ready toggled 1,0 each cycle -> still 128 rd_en pulses, no address repeated or skipped, done after 256+ cycles.
REQ-038 abort at stage 2 addr 10 -> IDLE next cycle, no done, rom_addr=0, stage_sel=0.
REQ-039 start held high across whole frame -> exactly one frame, done once, then new frame only after IDLE.
REQ-040 rst=0 asserted at stage 1 addr 31 -> all outputs 0 asynchronously; next start yields stage 0 addr 0.
REQ-041 coeff_valid/coeff_stage checked one cycle behind rd_en/stage_sel across stage wrap 31->0.
